// File: rtl/dual_port_ram_pipe.sv
// Simple dual-port RAM: one write port, one read port, single clock, byte enables,
// configurable read latency, read-during-write policy and optional post-reset clear.
module dual_port_ram_pipe #(
    parameter int                 DATA_W        = 8,
    parameter int                 ADDR_W        = 8,
    parameter int                 DEPTH         = 256,
    parameter int                 RD_LAT        = 1,
    parameter int                 RDW_MODE      = 0,
    parameter int                 INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL      = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  init_busy,
    output logic                  collision,
    output logic                  addr_err
);

    localparam int                BE_W      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                vld_q  [RD_LAT];
    logic                col_q  [RD_LAT];
    logic [DATA_W-1:0]   data_q [RD_LAT];
    logic                addr_err_q;

    logic                run;
    logic                wr_ok, rd_ok;
    logic                wr_acc, rd_acc;
    logic                col_d, addr_err_d;
    logic [DATA_W-1:0]   rd_word_d;

    assign run        = (state_q == ST_RUN);
    assign wr_ok      = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_ok      = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_acc     = run & wr_en & wr_ok;
    assign rd_acc     = run & rd_en;
    assign col_d      = rd_acc & wr_acc & (wr_addr == rd_addr);
    assign addr_err_d = run & ((wr_en & ~wr_ok) | (rd_en & ~rd_ok));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    // Storage is never reset; the clear sequence owns the write port while in INIT.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                mem[cnt_q] <= INIT_VAL;
            end else if (wr_acc) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Array read sees pre-write contents; forwarding overlays the enabled write bytes.
    always_comb begin
        rd_word_d = '0;
        if (rd_ok) rd_word_d = mem[rd_addr];
        if ((RDW_MODE == 1) && col_d) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) rd_word_d[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
    end

    // Data stages only load on a valid, so the last stage holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i]  <= 1'b0;
                col_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
            addr_err_q <= 1'b0;
        end else begin
            vld_q[0] <= rd_acc;
            col_q[0] <= col_d;
            if (rd_acc) data_q[0] <= rd_word_d;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                col_q[i] <= col_q[i-1];
                if (vld_q[i-1]) data_q[i] <= data_q[i-1];
            end
            addr_err_q <= addr_err_d;
        end
    end

    assign rd_data   = data_q[RD_LAT-1];
    assign rd_valid  = vld_q[RD_LAT-1];
    assign collision = col_q[RD_LAT-1];
    assign addr_err  = addr_err_q;
    assign init_busy = ~run;

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Directed bench for dual_port_ram_pipe: 32-bit, 200 entries, 3-cycle read latency,
// forwarding read-during-write, clear to A5A5A5A5 after reset.
module tb_dual_port_ram_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        init_busy;
    logic        collision;
    logic        addr_err;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] FILL = 32'hA5A5A5A5;

    dual_port_ram_pipe #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(3),
        .RDW_MODE(1), .INIT_ON_RESET(1), .INIT_VAL(FILL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .init_busy(init_busy),
        .collision(collision), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;
        logic [7:0]  ra;
        logic        ev;
        logic [31:0] ed;
        logic        ec;
        logic        ee;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input bit [31:0] we, wa, wd, be, re, ra, ev, ed, ec, ee);
        vec_t v;
        v.we = we[0];  v.wa = wa[7:0]; v.wd = wd; v.be = be[3:0];
        v.re = re[0];  v.ra = ra[7:0];
        v.ev = ev[0];  v.ed = ed;      v.ec = ec[0]; v.ee = ee[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_data"},   rd_data,   32'h0);
        chk({tag, "_rd_valid"},  {31'b0, rd_valid},  32'h0);
        chk({tag, "_collision"}, {31'b0, collision}, 32'h0);
        chk({tag, "_addr_err"},  {31'b0, addr_err},  32'h0);
        chk({tag, "_init_busy"}, {31'b0, init_busy}, 32'h1);
    endtask

    // Counts sampled cycles with init_busy high, starting at the release point.
    task automatic run_init(output int n, output int noisy);
        n = 0;
        noisy = 0;
        while (init_busy && n < 1000) begin
            if (rd_valid || addr_err || collision) noisy++;
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int noisy;
        int stale;

        vecs[0]  = mk(1, 0,   'h10,       'hF, 0, 0,   0, 0,           0, 0);
        vecs[1]  = mk(1, 1,   'h11,       'hF, 0, 0,   0, 0,           0, 0);
        vecs[2]  = mk(1, 2,   'h12,       'hF, 0, 0,   0, 0,           0, 0);
        vecs[3]  = mk(1, 3,   'h13,       'hF, 0, 0,   0, 0,           0, 0);
        vecs[4]  = mk(1, 3,   'hFFFFFFFF, 'h0, 1, 0,   0, 0,           0, 0);
        vecs[5]  = mk(0, 0,   0,          0,   1, 1,   0, 0,           0, 0);
        vecs[6]  = mk(0, 0,   0,          0,   1, 2,   1, 'h10,        0, 0);
        vecs[7]  = mk(0, 0,   0,          0,   1, 3,   1, 'h11,        0, 0);
        vecs[8]  = mk(1, 5,   'h11223344, 'hF, 0, 0,   1, 'h12,        0, 0);
        vecs[9]  = mk(1, 5,   'hAABBCCDD, 'h5, 0, 0,   1, 'h13,        0, 0);
        vecs[10] = mk(0, 0,   0,          0,   1, 5,   0, 'h13,        0, 0);
        vecs[11] = mk(0, 0,   0,          0,   0, 0,   0, 'h13,        0, 0);
        vecs[12] = mk(1, 7,   'h55,       'hF, 0, 0,   1, 'h11BB33DD,  0, 0);
        vecs[13] = mk(1, 7,   'h99999999, 'h3, 1, 7,   0, 'h11BB33DD,  0, 0);
        vecs[14] = mk(0, 0,   0,          0,   1, 7,   0, 'h11BB33DD,  0, 0);
        vecs[15] = mk(0, 0,   0,          0,   0, 0,   1, 'h00009999,  1, 0);
        vecs[16] = mk(1, 210, 'hFFFFFFFF, 'hF, 0, 0,   1, 'h00009999,  0, 1);
        vecs[17] = mk(0, 0,   0,          0,   0, 0,   0, 'h00009999,  0, 0);
        vecs[18] = mk(0, 0,   0,          0,   1, 210, 0, 'h00009999,  0, 1);
        vecs[19] = mk(1, 210, 'hFFFFFFFF, 'hF, 1, 210, 0, 'h00009999,  0, 1);
        vecs[20] = mk(0, 0,   0,          0,   1, 199, 1, 0,           0, 0);
        vecs[21] = mk(0, 0,   0,          0,   0, 0,   1, 0,           0, 0);
        vecs[22] = mk(0, 0,   0,          0,   1, 10,  1, FILL,        0, 0);
        vecs[23] = mk(0, 0,   0,          0,   1, 82,  0, FILL,        0, 0);
        vecs[24] = mk(0, 0,   0,          0,   0, 0,   1, FILL,        0, 0);
        vecs[25] = mk(0, 0,   0,          0,   0, 0,   1, FILL,        0, 0);
        vecs[26] = mk(0, 0,   0,          0,   0, 0,   0, FILL,        0, 0);

        // Reset values, then the clear sequence with requests that must be ignored.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        wr_en = 1'b1; wr_addr = 8'd250; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'd3;
        rst_n = 1'b1;
        run_init(n, noisy);
        idle_inputs();
        chk("init_len", n, 200);
        chk("init_quiet", noisy, 0);

        for (int i = 0; i < NVEC; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_be = vecs[i].be;
            rd_en = vecs[i].re; rd_addr = vecs[i].ra;
            tick();
            chk($sformatf("vec%0d_rd_valid", i),  {31'b0, rd_valid},  {31'b0, vecs[i].ev});
            chk($sformatf("vec%0d_rd_data", i),   rd_data,            vecs[i].ed);
            chk($sformatf("vec%0d_collision", i), {31'b0, collision}, {31'b0, vecs[i].ec});
            chk($sformatf("vec%0d_addr_err", i),  {31'b0, addr_err},  {31'b0, vecs[i].ee});
        end
        idle_inputs();

        // Reset in the middle of the clear restarts it from address 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("mid_init_busy", {31'b0, init_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        tick();
        rst_n = 1'b1;
        run_init(n, noisy);
        chk("reinit_len", n, 200);
        chk("reinit_quiet", noisy, 0);

        rd_en = 1'b1; rd_addr = 8'd5;
        tick();
        idle_inputs();
        tick();
        tick();
        chk("reclr_rd_valid", {31'b0, rd_valid}, 32'h1);
        chk("reclr_rd_data", rd_data, FILL);

        // Reset with two reads in flight: both results must be discarded.
        rd_en = 1'b1; rd_addr = 8'd0;
        tick();
        rd_addr = 8'd7;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("flight_rst");
        tick();
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rd_valid || collision) stale++;
        end
        chk("flight_stale", stale, 0);
        run_init(n, noisy);
        chk("flight_init_len", n + 6, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
